// File: rtl/beta_band_power_pkg.sv
// rtl/beta_band_power_pkg.sv - shared defaults and FSM state encoding for the band-power blocks
package beta_band_power_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int WIN_LOG2_DEF = 8;
  localparam int PWR_W_DEF    = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DUMP  = 2'd2
  } bp_state_t;

endpackage

// File: rtl/bp_square_stage.sv
// rtl/bp_square_stage.sv - registered signed square with valid delay, shared by all bands
module bp_square_stage
  import beta_band_power_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     x,
  input  logic                  in_valid,
  input  logic                  clear,
  output logic [2*DATA_W-1:0]   sq,
  output logic                  sq_v
);

  logic [2*DATA_W-1:0] w_x_ext;
  logic [2*DATA_W-1:0] w_sq;
  logic [2*DATA_W-1:0] r_sq;
  logic                r_sq_v;

  // Sign-extend first so the low 2*DATA_W product bits are the exact square.
  assign w_x_ext = {{DATA_W{x[DATA_W-1]}}, x};
  assign w_sq    = w_x_ext * w_x_ext;

  always_ff @(negedge clk) begin
    if (reset) begin
      r_sq   <= '0;
      r_sq_v <= 1'b0;
    end else begin
      r_sq_v <= in_valid & ~clear;
      if (in_valid) begin
        r_sq <= w_sq;
      end
    end
  end

  assign sq   = r_sq;
  assign sq_v = r_sq_v;

endmodule

// File: rtl/beta_band_power.sv
// rtl/beta_band_power.sv - windowed mean of squared filter output with threshold detect
module beta_band_power
  import beta_band_power_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int PWR_W    = PWR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  x,
  input  logic               in_valid,
  input  logic               clear,
  input  logic [PWR_W-1:0]   thresh,
  output logic [PWR_W-1:0]   power,
  output logic               out_valid,
  output logic               detect,
  output logic               busy
);

  localparam int ACC_W = 2*DATA_W + WIN_LOG2;

  logic [2*DATA_W-1:0] w_sq;
  logic                w_sq_v;
  logic [ACC_W-1:0]    w_sq_ext;
  logic [ACC_W-1:0]    w_sum;
  logic [PWR_W-1:0]    w_mean;
  logic                w_last;
  bp_state_t           r_state;
  bp_state_t           w_next_state;
  logic [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_count;
  logic [PWR_W-1:0]    r_power;
  logic                r_detect;

  bp_square_stage #(.DATA_W(DATA_W)) u_square (
    .clk      (clk),
    .reset    (reset),
    .x        (x),
    .in_valid (in_valid),
    .clear    (clear),
    .sq       (w_sq),
    .sq_v     (w_sq_v)
  );

  assign w_sq_ext = ACC_W'(w_sq);
  assign w_sum    = r_acc + w_sq_ext;
  assign w_mean   = PWR_W'(w_sum >> WIN_LOG2);
  assign w_last   = w_sq_v && (r_count == {WIN_LOG2{1'b1}});

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_sq_v) w_next_state = ST_ACCUM;
        ST_ACCUM: if (w_last) w_next_state = ST_DUMP;
        ST_DUMP:  w_next_state = w_sq_v ? ST_ACCUM : ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // Power/detect are captured on the edge entering DUMP so they are valid during the pulse.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_power  <= '0;
      r_detect <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (clear) begin
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        case (r_state)
          ST_ACCUM: begin
            if (w_last) begin
              r_acc    <= '0;
              r_count  <= '0;
              r_power  <= w_mean;
              r_detect <= (w_mean > thresh);
            end else if (w_sq_v) begin
              r_acc   <= w_sum;
              r_count <= r_count + WIN_LOG2'(1);
            end
          end
          default: begin
            r_acc   <= w_sq_v ? w_sq_ext : '0;
            r_count <= w_sq_v ? WIN_LOG2'(1) : '0;
          end
        endcase
      end
    end
  end

  assign power     = r_power;
  assign detect    = r_detect;
  assign out_valid = (r_state == ST_DUMP);
  assign busy      = (r_state == ST_ACCUM);

endmodule

// File: tb/tb_beta_band_power.sv
// tb/tb_beta_band_power.sv - directed self-checking bench for beta_band_power
module tb_beta_band_power;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x;
  logic        in_valid;
  logic        clear;
  logic [63:0] thresh;
  logic [63:0] power;
  logic        out_valid;
  logic        detect;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int p_before;
  int c1;

  always #5 clk = ~clk;

  beta_band_power dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .in_valid  (in_valid),
    .clear     (clear),
    .thresh    (thresh),
    .power     (power),
    .out_valid (out_valid),
    .detect    (detect),
    .busy      (busy)
  );

  // Outputs change on the falling edge; inputs are driven and outputs observed on the rising edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (out_valid === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [31:0] val, input int n, input int gap, input bit alt);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      x        = (alt && (i % 2 == 1)) ? -val : val;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = '0; in_valid = 1'b0; clear = 1'b0; thresh = 64'd999_999;
    tick(); tick();
    chk("rst_power", power, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_detect", {63'd0, detect}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();

    // 1: constant 1000, back-to-back
    pulses = 0;
    send(32'sd1000, 256, 0, 1'b0);
    chk("t1_no_early_pulse", {63'd0, out_valid}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_power", power, 64'd1_000_000);
    chk("t1_detect", {63'd0, detect}, 64'd1);
    tick();
    chk("t1_pulse_width", {63'd0, out_valid}, 64'd0);
    chk("t1_pulses", 64'(pulses), 64'd1);

    // 2: most negative sample, threshold boundary
    thresh = 64'h4000_0000_0000_0000;
    send(32'sh8000_0000, 256, 0, 1'b0);
    tick();
    chk("t2_power", power, 64'h4000_0000_0000_0000);
    chk("t2_detect_eq", {63'd0, detect}, 64'd0);
    thresh = 64'd0;
    repeat (3) tick();
    chk("t2_thresh_not_sampled", {63'd0, detect}, 64'd0);
    thresh = 64'h3FFF_FFFF_FFFF_FFFF;
    send(32'sh8000_0000, 256, 0, 1'b0);
    tick();
    chk("t2_detect_gt", {63'd0, detect}, 64'd1);
    chk("t2_power2", power, 64'h4000_0000_0000_0000);
    tick();

    // 3: alternating +/-3 every third cycle
    thresh = 64'd9;
    pulses = 0;
    send(32'sd3, 256, 2, 1'b1);
    chk("t3_no_early_pulse", 64'(pulses), 64'd0);
    tick();
    chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_power", power, 64'd9);
    chk("t3_detect", {63'd0, detect}, 64'd0);
    repeat (3) tick();
    chk("t3_pulses", 64'(pulses), 64'd1);

    // 4: 512 continuous samples, window boundary sample not dropped
    pulses = 0;
    send(32'sd10, 256, 0, 1'b0);
    send(32'sd20, 1, 0, 1'b0);
    chk("t4_pulse1", {63'd0, out_valid}, 64'd1);
    chk("t4_power1", power, 64'd100);
    c1 = last_pulse_cyc;
    send(32'sd20, 255, 0, 1'b0);
    tick();
    chk("t4_pulse2", {63'd0, out_valid}, 64'd1);
    chk("t4_power2", power, 64'd400);
    chk("t4_spacing", 64'(last_pulse_cyc - c1), 64'd256);
    chk("t4_pulses", 64'(pulses), 64'd2);
    tick();

    // 5: clear mid-window with a coincident sample
    send(32'sd5, 100, 0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; x = 32'd5;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    tick();
    chk("t5_busy_after_clear", {63'd0, busy}, 64'd0);
    chk("t5_power_held", power, 64'd400);
    p_before = pulses;
    send(32'sd2, 256, 0, 1'b0);
    chk("t5_no_early_pulse", 64'(pulses - p_before), 64'd0);
    tick();
    chk("t5_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_power", power, 64'd4);
    tick();

    // 6: reset mid-window
    thresh = 64'd0;
    send(32'sd9, 200, 0, 1'b0);
    reset = 1'b1;
    tick();
    chk("t6_rst_power", power, 64'd0);
    chk("t6_rst_detect", {63'd0, detect}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    p_before = pulses;
    repeat (4) tick();
    chk("t6_no_partial_pulse", 64'(pulses - p_before), 64'd0);
    send(32'sd7, 256, 0, 1'b0);
    tick();
    chk("t6_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t6_power", power, 64'd49);
    chk("t6_detect", {63'd0, detect}, 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
